pll_phase_ctrl: RTL

//  Sequencer for the ECP5 EHXPLLL lock and dynamic-phase ports. Synchronises LOCK, holds the

---
 rtl/pll_phase_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/pll_phase_ctrl.sv
// pll_phase_ctrl: ECP5 EHXPLLL lock sequencer and dynamic phase-step driver (optional tracker: PLL_PHASE_TRACK_EN)
module pll_phase_ctrl #(
  parameter int LOCK_WAIT = 1024,
  parameter int SETUP_CYC = 4,
  parameter int PULSE_CYC = 4,
  parameter int GAP_CYC   = 4,
  parameter int STEP_W    = 8,
  parameter int PHASE_MOD = 40
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              pll_locked,
  output logic              sys_reset_n,
  output logic              lock_lost,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_sel,
  input  logic              req_dir,
  input  logic [STEP_W-1:0] req_steps,
  output logic              done,
  output logic              aborted,
  output logic [1:0]        pll_phasesel,
  output logic              pll_phasedir,
  output logic              pll_phasestep,
  output logic              pll_phaseload,
  output logic [23:0]       phase_pos
);
  localparam int LW   = $clog2(LOCK_WAIT + 1);
  localparam int MC0  = SETUP_CYC > PULSE_CYC ? SETUP_CYC : PULSE_CYC;
  localparam int MAXC = MC0 > GAP_CYC ? MC0 : GAP_CYC;
  localparam int TW   = $clog2(MAXC + 1);
  typedef enum logic [2:0] {IDLE, SETUP, STEP, GAP, LOAD, DONE} state_t;
  state_t state, nstate;
  logic s1, lk;
  logic [LW-1:0] cnt;
  logic [TW-1:0] tmr, tlim;
  logic [STEP_W-1:0] rem;
  logic ab, busy, tend, accept, step_done;
  assign busy          = state inside {SETUP, STEP, GAP, LOAD};
  assign req_ready     = state == IDLE && sys_reset_n;
  assign accept        = req_valid && req_ready;
  assign tlim          = state == SETUP ? TW'(SETUP_CYC - 1) : state == GAP ? TW'(GAP_CYC - 1) : TW'(PULSE_CYC - 1);
  assign tend          = tmr == tlim;
  assign step_done     = state == STEP && nstate == GAP;
  assign done          = state == DONE;
  assign aborted       = done && ab;
  assign pll_phasestep = !(state == STEP && sys_reset_n);
  assign pll_phaseload = !(state == LOAD && sys_reset_n);
  // Synchronise LOCK and release the design reset only after a continuous locked window
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1          <= 1'b0;
      lk          <= 1'b0;
      cnt         <= '0;
      sys_reset_n <= 1'b0;
      lock_lost   <= 1'b0;
    end else begin
      s1          <= pll_locked;
      lk          <= s1;
      cnt         <= !lk ? '0 : cnt != LW'(LOCK_WAIT) ? cnt + LW'(1) : cnt;
      sys_reset_n <= lk && cnt >= LW'(LOCK_WAIT - 1);
      lock_lost   <= lock_lost || (sys_reset_n && !lk);
    end
  end
  // Sequencer state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= nstate;
  end
  // Sequencer next state; any loss of lock while busy cuts straight to DONE
  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (accept) nstate = req_steps == '0 ? DONE : SETUP;
      SETUP:   if (tend) nstate = STEP;
      STEP:    if (tend) nstate = GAP;
      GAP:     if (tend) nstate = rem != '0 ? STEP : LOAD;
      LOAD:    if (tend) nstate = DONE;
      default: nstate = IDLE;
    endcase
    if (busy && !sys_reset_n) nstate = DONE;
  end
  // Phase timer, remaining-step count, PHASESEL/PHASEDIR hold and abort flag
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tmr          <= '0;
      rem          <= '0;
      pll_phasesel <= 2'd0;
      pll_phasedir <= 1'b1;
      ab           <= 1'b0;
    end else begin
      tmr <= busy && nstate == state ? tmr + TW'(1) : '0;
      rem <= accept ? req_steps : step_done ? rem - STEP_W'(1) : rem;
      if (accept && req_steps != '0) begin
        pll_phasesel <= req_sel;
        pll_phasedir <= req_dir;
      end
      ab <= (busy && !sys_reset_n) || (ab && state != DONE);
    end
  end
`ifdef PLL_PHASE_TRACK_EN
  logic [3:0][5:0] pos;
  assign phase_pos = pos;
  // Track each output's phase position, counting only completed step pulses
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) pos <= '0;
    else if (step_done)
      pos[pll_phasesel] <= pll_phasedir ?
        (pos[pll_phasesel] == 6'(PHASE_MOD - 1) ? 6'd0 : pos[pll_phasesel] + 6'd1) :
        (pos[pll_phasesel] == 6'd0 ? 6'(PHASE_MOD - 1) : pos[pll_phasesel] - 6'd1);
  end
`else
  assign phase_pos = '0;
`endif
endmodule
